// File: rtl/frame_arb_pkg.sv
// Shared types and constants for the frame arbiter: FSM states, framing
// bytes and payload geometry.
package frame_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SYNC    = 3'd2,
    HDR     = 3'd3,
    PAYLOAD = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_FF   = 8'hFF;
  localparam logic [7:0] SYNC_BYTE_LAST = 8'h7F;
  localparam logic [3:0] HDR_TAG        = 4'hA;
  localparam int         PAYLOAD_BYTES  = 16;
  localparam int         SYNC_LEN       = 4;
  localparam int         SRC_IDX_W      = 2;

  // Header byte carrying the tag and the id of the granted source.
  function automatic logic [7:0] hdr_byte(input logic [SRC_IDX_W-1:0] src_id);
    return {HDR_TAG, 2'b00, src_id};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first requester found after the
// last granted index wins; returns a one-hot grant and its index.
module rr_picker
  import frame_arb_pkg::*;
#(
  parameter int NSRC = 2
) (
  input  logic [NSRC-1:0]      req_i,
  input  logic [SRC_IDX_W-1:0] last_i,
  output logic [NSRC-1:0]      grant_o,
  output logic [SRC_IDX_W-1:0] idx_o,
  output logic                 any_o
);

  // Scan NSRC candidates starting just after the last grant, wrapping around.
  always_comb begin
    int   cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = (int'(last_i) + k) % NSRC;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand[SRC_IDX_W-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/frame_arbiter.sv
// Frame arbiter: takes 128-bit packets from up to four sources round-robin
// and streams each one as an optional sync sequence, a header byte and
// sixteen payload bytes, one byte per downstream request.
module frame_arbiter
  import frame_arb_pkg::*;
#(
  parameter int NSRC          = 2,
  parameter int SYNC_INTERVAL = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NSRC-1:0]     src_valid,
  input  logic [NSRC*128-1:0] src_packet,
  output logic [NSRC-1:0]     src_ack,
  input  logic                force_sync,
  input  logic                out_next,
  output logic [7:0]          out_data,
  output logic                out_ready,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  state_t                 state_q, state_d;
  logic [NSRC-1:0]        sel_oh_q, sel_oh_d;
  logic [SRC_IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic [SRC_IDX_W-1:0]   last_q, last_d;
  logic [127:0]           pkt_q, pkt_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_ready_q, out_ready_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   sync_pend_q, sync_pend_d;
  logic [7:0]             intv_q, intv_d;

  logic [NSRC-1:0]        rr_grant;
  logic [SRC_IDX_W-1:0]   rr_idx;
  logic                   rr_any;
  logic [127:0]           pkt_sel;

  rr_picker #(.NSRC(NSRC)) u_rr (
    .req_i   (src_valid),
    .last_i  (last_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // Packet of the currently selected source (one-hot AND-OR mux).
  always_comb begin
    pkt_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_oh_q[i]) pkt_sel = pkt_sel | src_packet[i*128 +: 128];
    end
  end

  // Next-state, byte emission and sync bookkeeping.
  always_comb begin
    state_d     = state_q;
    sel_oh_d    = sel_oh_q;
    sel_idx_d   = sel_idx_q;
    last_d      = last_q;
    pkt_d       = pkt_q;
    byte_cnt_d  = byte_cnt_q;
    out_data_d  = out_data_q;
    out_ready_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    sync_pend_d = sync_pend_q;
    intv_d      = intv_q;
    src_ack     = '0;

    case (state_q)
      IDLE: begin
        if (rr_any) begin
          sel_oh_d  = rr_grant;
          sel_idx_d = rr_idx;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        // A source that dropped its request before this cycle is not granted
        // and the round-robin pointer is left untouched.
        if (|(sel_oh_q & src_valid)) begin
          src_ack    = sel_oh_q;
          pkt_d      = pkt_sel;
          last_d     = sel_idx_q;
          byte_cnt_d = '0;
          state_d    = sync_pend_q ? SYNC : HDR;
        end else begin
          state_d = IDLE;
        end
      end
      SYNC: begin
        if (out_next) begin
          out_ready_d = 1'b1;
          if (byte_cnt_q == 4'(SYNC_LEN - 1)) begin
            out_data_d  = SYNC_BYTE_LAST;
            byte_cnt_d  = '0;
            sync_pend_d = 1'b0;
            intv_d      = '0;
            state_d     = HDR;
          end else begin
            out_data_d = SYNC_BYTE_FF;
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      HDR: begin
        if (out_next) begin
          out_ready_d = 1'b1;
          out_data_d  = hdr_byte(sel_idx_q);
          byte_cnt_d  = '0;
          state_d     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (out_next) begin
          out_ready_d = 1'b1;
          out_data_d  = pkt_q[{byte_cnt_q, 3'b000} +: 8];
          if (byte_cnt_q == 4'(PAYLOAD_BYTES - 1)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            intv_d      = intv_q + 8'd1;
            if (({1'b0, intv_q} + 9'd1) >= 9'(SYNC_INTERVAL)) sync_pend_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A force request always wins, even over the clear at the end of SYNC,
    // so a request arriving during a sync carries over to the next frame.
    if (force_sync) sync_pend_d = 1'b1;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_oh_q    <= '0;
      sel_idx_q   <= '0;
      last_q      <= SRC_IDX_W'(NSRC - 1);
      pkt_q       <= '0;
      byte_cnt_q  <= '0;
      out_data_q  <= '0;
      out_ready_q <= 1'b0;
      frame_cnt_q <= '0;
      sync_pend_q <= 1'b1;
      intv_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_oh_q    <= sel_oh_d;
      sel_idx_q   <= sel_idx_d;
      last_q      <= last_d;
      pkt_q       <= pkt_d;
      byte_cnt_q  <= byte_cnt_d;
      out_data_q  <= out_data_d;
      out_ready_q <= out_ready_d;
      frame_cnt_q <= frame_cnt_d;
      sync_pend_q <= sync_pend_d;
      intv_q      <= intv_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ready = out_ready_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
